// File: rtl/mips_bus_master.sv
// mips_bus_master: CPU load/store to word-bus initiator; ports clk/reset, req_* (CPU side), rsp_* (completion), busy, bus (address/read/write/waitrequest/writedata/byteenable/readdata); optional BUS_TIMEOUT_EN aborts after MAX_WAIT stalled cycles
module mips_bus_master #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, RDWAIT = 2'd2, RESP = 2'd3;
  logic [1:0]  state;
  logic        wr_q, sgn_q, err_q, mis, tmo, in_bus;
  logic [31:0] addr_q, wdata_q, rdata_q, sh, ext, wd;
  logic [1:0]  size_q;
  logic [3:0]  be;
  assign mis = (req_size == 2'd3) | (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & |req_addr[1:0]);
  assign in_bus = state == BUS;
  assign sh = readdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    be  = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] : size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd  = size_q == 2'd0 ? {4{wdata_q[7:0]}} : size_q == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
    ext = size_q == 2'd0 ? {{24{sgn_q & sh[7]}}, sh[7:0]} : size_q == 2'd1 ? {{16{sgn_q & sh[15]}}, sh[15:0]} : sh;
  end
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign rsp_valid  = state == RESP;
  assign rsp_err    = rsp_valid & err_q;
  assign rsp_rdata  = rdata_q;
  assign address    = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
  assign read       = in_bus & ~wr_q;
  assign write      = in_bus & wr_q;
  assign byteenable = in_bus ? be : 4'd0;
  assign writedata  = in_bus & wr_q ? wd : 32'd0;
`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_WAIT + 1) < 8) ? 8 : $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt;
  // Abort on the edge that would complete the MAX_WAIT-th stalled cycle.
  assign tmo = waitrequest && (({1'b0, cnt} + 1'b1) >= (CW + 1)'(MAX_WAIT));
  always_ff @(posedge clk)
    if (reset || !in_bus) cnt <= '0;
    else cnt <= cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          addr_q  <= req_addr;
          size_q  <= req_size;
          sgn_q   <= req_signed;
          wdata_q <= req_wdata;
          err_q   <= mis;
          if (mis) rdata_q <= 32'd0;
          state   <= mis ? RESP : BUS;
        end
        BUS: if (tmo) begin
          err_q   <= 1'b1;
          rdata_q <= 32'd0;
          state   <= RESP;
        end else if (!waitrequest) begin
          err_q <= 1'b0;
          if (wr_q) rdata_q <= 32'd0;
          state <= wr_q ? RESP : RDWAIT;
        end
        RDWAIT: begin
          rdata_q <= ext;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_bus_master.sv
// tb_mips_bus_master: directed self-checking bench for mips_bus_master
module tb_mips_bus_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, busy, write, read;
  logic [31:0] rsp_rdata, address, writedata;
  logic [3:0]  byteenable;
  int n_checks = 0, n_fail = 0;

  mips_bus_master #(.MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_signed(req_signed), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy), .address(address),
    .write(write), .read(read), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] wdat);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wdat;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL rst_rw got %b%b exp 00", read, write); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_rsp got v%b e%b b%b exp 000", rsp_valid, rsp_err, busy); end
    n_checks++; if (rsp_rdata !== 32'd0 || address !== 32'd0 || byteenable !== 4'd0) begin n_fail++; $display("FAIL rst_data got %h %h %h exp 0", rsp_rdata, address, byteenable); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    readdata = 32'h0000000F; waitrequest = 1'b0;
    issue(1'b0, 32'hBFC0002C, 2'd2, 1'b0, 32'd0);
    n_checks++; if (read !== 1'b1 || write !== 1'b0) begin n_fail++; $display("FAIL wl_read got r%b w%b exp r1 w0", read, write); end
    n_checks++; if (address !== 32'hBFC0002C) begin n_fail++; $display("FAIL wl_addr got %h exp bfc0002c", address); end
    n_checks++; if (byteenable !== 4'b1111) begin n_fail++; $display("FAIL wl_be got %b exp 1111", byteenable); end
    n_checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wl_busy got rdy%b busy%b exp 0 1", req_ready, busy); end
    step();
    n_checks++; if (read !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wl_rdwait got r%b v%b exp 0 0", read, rsp_valid); end
    step();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL wl_rsp got v%b e%b exp 1 0", rsp_valid, rsp_err); end
    n_checks++; if (rsp_rdata !== 32'h0000000F) begin n_fail++; $display("FAIL wl_data got %h exp 0000000f", rsp_rdata); end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL wl_done got v%b rdy%b exp 0 1", rsp_valid, req_ready); end
    n_checks++; if (rsp_rdata !== 32'h0000000F) begin n_fail++; $display("FAIL wl_hold got %h exp 0000000f", rsp_rdata); end
  endtask

  task automatic test_subword_load();
    logic [31:0] exp_b [2];
    logic [31:0] exp_h [2];
    exp_b[0] = 32'h00000080; exp_b[1] = 32'hFFFFFF80;
    exp_h[0] = 32'h000080FF; exp_h[1] = 32'hFFFF80FF;
    readdata = 32'h80FF1234;
    for (int s = 0; s < 2; s++) begin
      issue(1'b0, 32'hBFC00013, 2'd0, s[0], 32'd0);
      n_checks++; if (address !== 32'hBFC00010 || byteenable !== 4'b1000) begin n_fail++; $display("FAIL bl_bus[%0d] got %h %b exp bfc00010 1000", s, address, byteenable); end
      step(); step();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_b[s]) begin n_fail++; $display("FAIL bl_data[%0d] got v%b %h exp 1 %h", s, rsp_valid, rsp_rdata, exp_b[s]); end
      step();
    end
    for (int s = 0; s < 2; s++) begin
      issue(1'b0, 32'hBFC00012, 2'd1, s[0], 32'd0);
      n_checks++; if (byteenable !== 4'b1100) begin n_fail++; $display("FAIL hl_be[%0d] got %b exp 1100", s, byteenable); end
      step(); step();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_h[s]) begin n_fail++; $display("FAIL hl_data[%0d] got v%b %h exp 1 %h", s, rsp_valid, rsp_rdata, exp_h[s]); end
      step();
    end
  endtask

  task automatic test_half_store();
    waitrequest = 1'b1;
    issue(1'b1, 32'hBFC00012, 2'd1, 1'b0, 32'h0000BEEF);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (write !== 1'b1 || read !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL hs_strobe[%0d] got w%b r%b v%b exp 1 0 0", i, write, read, rsp_valid); end
      n_checks++; if (address !== 32'hBFC00010 || byteenable !== 4'b1100 || writedata !== 32'hBEEFBEEF) begin n_fail++; $display("FAIL hs_bus[%0d] got %h %b %h exp bfc00010 1100 beefbeef", i, address, byteenable, writedata); end
      if (i == 3) waitrequest = 1'b0;
      step();
    end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0 || write !== 1'b0) begin n_fail++; $display("FAIL hs_rsp got v%b e%b %h w%b exp 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, write); end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL hs_single got v%b rdy%b exp 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_misaligned();
    logic [31:0] a [3];
    logic [1:0]  z [3];
    a[0] = 32'hBFC00001; z[0] = 2'd2;
    a[1] = 32'hBFC00003; z[1] = 2'd1;
    a[2] = 32'hBFC00000; z[2] = 2'd3;
    readdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, a[i], z[i], 1'b0, 32'd0);
      n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL mis_nobus[%0d] got r%b w%b exp 0 0", i, read, write); end
      n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL mis_rsp[%0d] got v%b e%b %h exp 1 1 0", i, rsp_valid, rsp_err, rsp_rdata); end
      step();
      n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL mis_done[%0d] got v%b e%b rdy%b exp 0 0 1", i, rsp_valid, rsp_err, req_ready); end
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    waitrequest = 1'b1; readdata = 32'hCAFEF00D;
    issue(1'b0, 32'hBFC00020, 2'd2, 1'b0, 32'd0);
    step();
    n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL rm_read got %b exp 1", read); end
    reset = 1'b1;
    step();
    n_checks++; if (read !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_after got r%b v%b rdy%b b%b exp 0 0 1 0", read, rsp_valid, req_ready, busy); end
    reset = 1'b0; waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rm_norsp got %0d pulses exp 0", pulses); end
    issue(1'b0, 32'hBFC00024, 2'd2, 1'b1, 32'd0);
    step(); step();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rm_next got v%b e%b %h exp 1 0 cafef00d", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_w, exp_v, got_w, got_v;
    exp_w = 6'b001001; exp_v = 6'b010010; got_w = '0; got_v = '0;
    waitrequest = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'hBFC00041; req_size = 2'd0; req_wdata = 32'h123456A5;
    step();
    n_checks++; if (byteenable !== 4'b0010 || writedata !== 32'hA5A5A5A5 || address !== 32'hBFC00040) begin n_fail++; $display("FAIL bb_lane got %b %h %h exp 0010 a5a5a5a5 bfc00040", byteenable, writedata, address); end
    for (int i = 0; i < 6; i++) begin
      got_w[i] = write; got_v[i] = rsp_valid;
      if (i == 3) req_valid = 1'b0;
      step();
    end
    n_checks++; if (got_w !== exp_w) begin n_fail++; $display("FAIL bb_write got %b exp %b", got_w, exp_w); end
    n_checks++; if (got_v !== exp_v) begin n_fail++; $display("FAIL bb_rsp got %b exp %b", got_v, exp_v); end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    waitrequest = 1'b1;
    issue(1'b0, 32'hBFC00080, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (read !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_read[%0d] got r%b v%b exp 1 0", i, read, rsp_valid); end
      step();
    end
    n_checks++; if (read !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL to_abort got r%b v%b e%b %h exp 0 1 1 0", read, rsp_valid, rsp_err, rsp_rdata); end
    waitrequest = 1'b0;
    step();
  endtask
`else
  task automatic test_timeout();
    int reads = 0;
    waitrequest = 1'b1; readdata = 32'h00C0FFEE;
    issue(1'b0, 32'hBFC00080, 2'd2, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (read === 1'b1 && rsp_valid === 1'b0) reads++;
      step();
    end
    n_checks++; if (reads != 10) begin n_fail++; $display("FAIL nt_hold got %0d exp 10", reads); end
    waitrequest = 1'b0;
    step(); step();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00C0FFEE) begin n_fail++; $display("FAIL nt_rsp got v%b e%b %h exp 1 0 00c0ffee", rsp_valid, rsp_err, rsp_rdata); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_subword_load();
    test_half_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_bus_master.md
Name: mips_bus_master

Overview:
- Initiator side of the CPU memory bus. Address, read, write, waitrequest, writedata, byteenable and readdata follow the bus already used by mips_cpu_bus.
- Accepts one load/store request at a time from the CPU datapath.
- Issues one word-aligned bus transaction for each request, holding it through waitrequest stalls.
- Returns load data extracted and extended to 32 bits, or a completion/error pulse for stores and misaligned accesses.

Parameters:
- MAX_WAIT, 255, waitrequest cycles tolerated before abort; used only with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  CPU request present
- req_ready  out  1  block is able to accept a request
- req_write  in  1  1=store, 0=load
- req_addr  in  32  byte address
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as misaligned)
- req_signed  in  1  sign-extend byte/half loads
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: misaligned or timeout
- rsp_rdata  out  32  load result, valid with rsp_valid
- busy  out  1  any state other than IDLE
- address  out  32  word address on the bus, address[1:0]=0
- write  out  1  bus write strobe
- read  out  1  bus read strobe
- waitrequest  in  1  responder stall
- writedata  out  32  lane-positioned store data
- byteenable  out  4  active lanes
- readdata  in  32  word from responder, valid 1 cycle after read accepted

Behaviour:
- Reset: synchronous, active-high. At the first posedge with reset=1 all outputs go to 0 except req_ready, and the state goes to IDLE.
  - req_ready=1 while reset is held.
  - A transaction in progress is dropped with no rsp_valid.
  - read and write are low in the cycle after that edge.
- States: IDLE, BUS, RDWAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch request fields and compute offset=req_addr[1:0].
  - Misaligned request (half with odd offset, word with offset!=0, or size 3): go to RESP with rsp_err=1 and rsp_rdata=0. No bus cycle is issued.
  - Otherwise go to BUS.
- BUS:
  - Drive address={addr[31:2],2'b00}, plus read or write, byteenable and writedata. All are held stable while waitrequest=1.
  - The transfer is accepted on the edge where waitrequest=0.
  - After acceptance, a write goes to RESP and a read goes to RDWAIT.
  - read and write are 0 in every other state.
- Lane mapping: byte at offset k uses byteenable bit k and data bits [8k+7:8k].
  - Byte: byteenable=1<<k, writedata=req_wdata[7:0] replicated on all 4 lanes.
  - Half: byteenable=4'b0011 (k=0) or 4'b1100 (k=2), writedata=req_wdata[15:0] replicated.
  - Word: byteenable=4'b1111, writedata=req_wdata.
  - byteenable is also driven on reads.
- RDWAIT: capture readdata on the following edge, select the lanes, then zero- or sign-extend per req_signed. Word loads ignore req_signed. Go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Request handling outside IDLE:
  - req_ready=0 in BUS, RDWAIT and RESP; req_valid is ignored there.
  - A new request can be accepted in the cycle after RESP, so the minimum spacing is one request every 3 cycles for stores and 4 for loads.
- Latency with zero wait states, counted from the accepting edge:
  - Store: write high in cycle +1, rsp_valid in cycle +2.
  - Load: read in cycle +1, data captured at +2, rsp_valid in cycle +3.
  - Each waitrequest cycle adds one cycle.
- rsp_rdata holds its value until the next RESP. It is 0 for stores.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter, sized to hold MAX_WAIT, counts consecutive cycles in BUS with waitrequest=1.
  - When the count reaches MAX_WAIT, deassert read/write, go to RESP with rsp_err=1 and rsp_rdata=0.
  - The counter clears on entry to BUS.
- Undefined: no counter. BUS waits indefinitely; rsp_err is raised only for misalignment.

Test Plan:
- Word load, zero wait: addr 0xBFC0002C with responder word 0x0000000F → address=0xBFC0002C, byteenable=4'b1111, read for 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=0x0000000F, rsp_err=0.
- Signed byte load, offset 3, word 0x80FF1234: signed → rsp_rdata=0xFFFFFF80; unsigned → 0x00000080.
- Half store to addr 0xBFC00012, data 0x0000BEEF, waitrequest high for 3 cycles → address/byteenable=4'b1100/writedata=0xBEEFBEEF stable all 4 BUS cycles, single rsp_valid.
- Misaligned word load at 0xBFC00001 → no read pulse, rsp_valid with rsp_err=1 in cycle +1, rsp_rdata=0.
- Reset asserted while in BUS with waitrequest=1 → read=0 after the edge, no rsp_valid, req_ready=1, next request completes normally.
- BUS_TIMEOUT_EN with MAX_WAIT=4, waitrequest stuck high → read high exactly 4 cycles, then rsp_valid with rsp_err=1.
